pipeline_stall_ctrl: RTL
========================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_rs  input  5  rs field of instruction in ID.
REQ-005 id_rt  input  5  rt field of instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 ex_rt  input  5  destination rt of instruction in EX.
REQ-008 ex_mem_read  input  1  EX instruction is a load.
REQ-009 branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-011 clr_stats  input  1  synchronous clear of stall_cycles.
REQ-012 pc_en  output  1  PC register load enable.
REQ-013 ifid_en  output  1  IF/ID register enable.
REQ-014 idex_en  output  1  ID/EX register enable, including the registered sign-extension output.
REQ-015 ifid_flush  output  1  IF/ID loads a NOP.
REQ-016 idex_flush  output  1  ID/EX loads a bubble; all control bits zero.
REQ-017 state  output  2  current FSM state.
REQ-018 stall_cycles  output  CNT_W  count of cycles with pc_en=0.

Function
REQ-019 The FSM SHALL have the states RUN, LOAD_STALL, FLUSH and MEM_WAIT; state is registered, and the enable and flush outputs SHALL be combinational in state and current inputs, so a hazard takes effect in the cycle it is presented.
REQ-020 The load-use hazard SHALL be ex_mem_read AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-021 Priority SHALL be mem_busy > branch_taken > load-use.
REQ-022 In any state, mem_busy=1: all enables 0, no flush, next state MEM_WAIT.
REQ-023 MEM_WAIT with mem_busy=0: outputs as RUN evaluated on current inputs, next state per RUN rules; branch_taken/hazard held during the freeze are not lost.
REQ-024 RUN with branch_taken=1: pc_en=ifid_en=idex_en=1, ifid_flush=idex_flush=1, next FLUSH.
REQ-025 RUN with load-use hazard: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, next LOAD_STALL.
REQ-026 RUN with no event: all enables 1, flushes 0, stay RUN.
REQ-027 LOAD_STALL: all enables 1, flushes 0, hazard check suppressed, next RUN; branch_taken still honoured per REQ-024.
REQ-028 FLUSH: all enables 1, flushes 0, load-use check suppressed for the flushed slot, next RUN; branch_taken honoured per REQ-024.
REQ-029 stall_cycles SHALL increment each cycle pc_en=0, saturate at all-ones, and clear on clr_stats; clr_stats wins over an increment in the same cycle.

Reset
REQ-030 rst=1 SHALL immediately force state=RUN and stall_cycles=0, giving all enables 1 and flushes 0 (absent mem_busy); assertion mid-stall or mid-freeze SHALL abort it without a further stall cycle.

Structure
REQ-031 State encodings RUN=2'b00, LOAD_STALL=2'b01, FLUSH=2'b10, MEM_WAIT=2'b11 SHALL live in the shared pipeline package.
REQ-032 The REQ-020 comparator SHALL be a sub-module load_use_detect (combinational) instantiated once.

Verification
REQ-033 Load r5 in EX (ex_mem_read=1, ex_rt=5), ID rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, state LOAD_STALL next, then RUN; stall_cycles=1.
REQ-034 ex_rt=0 with id_rs=0, ex_mem_read=1 -> no stall; also ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-035 branch_taken=1 in RUN -> ifid_flush=idex_flush=1 for one cycle, state FLUSH, then RUN; a load-use match during FLUSH produces no stall.
REQ-036 mem_busy=1 for 3 cycles while branch_taken=1 -> enables 0 for 3 cycles, state MEM_WAIT, flush on the 4th cycle; stall_cycles=3.
REQ-037 CNT_W=4, mem_busy held 20 cycles -> stall_cycles saturates at 15; clr_stats=1 -> 0 next edge.
REQ-038 rst pulsed asynchronously during MEM_WAIT with mem_busy=0 -> state=RUN, stall_cycles=0 before the next clock edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// ============================================================================
// pipeline_stall_ctrl_pkg
// Shared pipeline types: stall FSM state encodings and register-field width.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } stall_state_t;

endpackage : pipeline_stall_ctrl_pkg

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// ============================================================================
// load_use_detect
// Combinational load-use comparator between the EX load and the ID sources.
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  logic w_dest_live;
  logic w_rs_match;
  logic w_rt_match;

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign w_dest_live = ex_mem_read && (ex_rt != '0);
  assign w_rs_match  = (ex_rt == id_rs);
  assign w_rt_match  = id_uses_rt && (ex_rt == id_rt);
  assign hazard      = w_dest_live && (w_rs_match || w_rt_match);

endmodule : load_use_detect

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl
// Stall/flush controller: memory freeze, branch flush and load-use interlock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  clr_stats,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_cycles
);

  stall_state_t     r_state;
  stall_state_t     w_next_state;
  logic             w_hazard;
  logic             w_hazard_armed;
  logic [CNT_W-1:0] r_stall_cycles;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .hazard      (w_hazard)
  );

  // The slot after a stall or a flush already holds a bubble, so the check is skipped
  assign w_hazard_armed = (r_state == RUN) || (r_state == MEM_WAIT);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    w_next_state = RUN;

    if (mem_busy) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      w_next_state = MEM_WAIT;
    end else if (branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      w_next_state = FLUSH;
    end else if (w_hazard && w_hazard_armed) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_flush   = 1'b1;
      w_next_state = LOAD_STALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Saturating count of frozen-PC cycles; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (clr_stats) begin
      r_stall_cycles <= '0;
    end else if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cycles;

endmodule : pipeline_stall_ctrl

`default_nettype wire
